// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and constants for the UART transmit arbiter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, ACK} state_e;
  localparam int BYTE_W      = 8;
  localparam int TIMEOUT_DEF = 32;
endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: combinational round-robin pick, searching from ptr+1 with wrap to 0.
module rr_select #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         winner,
  output logic               valid
);
  logic [7:0] req_ext;
  logic [3:0] sum;
  logic [2:0] idx;
  always_comb begin
    req_ext = 8'(req);
    valid   = |req;
    winner  = '0;
    sum     = '0;
    idx     = '0;
    // Walk offsets from farthest to nearest so the nearest requester overwrites last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = 4'(ptr) + 4'(k);
      idx = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : 3'(sum);
      if (req_ext[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding one UART transmitter, with done timeout.
// Define UART_ARB_URGENT_EN to let requester 0 win every arbitration it takes part in.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                      tx_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      load_send,
  output logic [BYTE_W-1:0]         data_in,
  input  logic                      done,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic                      err
);
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  state_e            state_q, state_d;
  logic [BYTE_W-1:0] data_q, data_d, sel_data;
  logic [2:0]        gid_q, gid_d, ptr_q, ptr_d, rr_id, sel_id, ptr_upd;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d, rr_valid, timeout;
  rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .winner (rr_id),
    .valid  (rr_valid)
  );
`ifdef UART_ARB_URGENT_EN
  assign sel_id  = req[0] ? 3'd0 : rr_id;
  assign ptr_upd = (gid_q == 3'd0) ? ptr_q : gid_q;
`else
  assign sel_id  = rr_id;
  assign ptr_upd = gid_q;
`endif
  assign timeout = cnt_q == CW'(TIMEOUT_CYC - 1);
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel_id == 3'(i)) sel_data = req_data[BYTE_W*i +: BYTE_W];
  end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (rr_valid) begin
        state_d = LOAD;
        data_d  = sel_data;
        gid_d   = sel_id;
      end
      LOAD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (done || timeout) ? ACK : WAIT;
        err_d   = err_q | (!done && timeout);
      end
      ACK: begin
        state_d = IDLE;
        ptr_d   = ptr_upd;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= 3'(NUM_REQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign load_send = state_q == LOAD;
  assign busy      = state_q != IDLE;
  assign ack       = (state_q == ACK) ? NUM_REQ'(1) << gid_q : '0;
  assign data_in   = data_q;
  assign grant_id  = gid_q;
  assign err       = err_q;
endmodule
